// File: rtl/projection_border.sv
// Projection-based border finder for a binary image stream.
// Frame 0 projects foreground rows into row segments and builds a column
// occupancy bitmap; frame 1 scans that bitmap on line 0 to extract column
// segments; frame 2 holds the results stable for readout.
module projection_border #(
  parameter int H_DISP  = 640,
  parameter int V_DISP  = 480,
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        data_en,
  input  logic        monoc,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [10:0] row_border_addr,
  output logic [10:0] row_border_data,
  input  logic [10:0] col_border_addr,
  output logic [10:0] col_border_data,
  output logic [1:0]  frame_cnt,
  output logic        project_done_flag,
  output logic [3:0]  num_row,
  output logic [3:0]  num_col
);

  localparam int          XW       = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam logic [10:0] LP_XLAST = 11'(H_DISP - 1);
  localparam logic [10:0] LP_YLAST = 11'(V_DISP - 1);
  localparam logic [10:0] LP_XCNT  = 11'(H_DISP);
  localparam logic [3:0]  LP_NROW  = 4'(NUM_ROW);
  localparam logic [3:0]  LP_NCOL  = 4'(NUM_COL);

  typedef enum logic [1:0] {
    S_WAIT,
    S_FRAME0,
    S_FRAME1,
    S_FRAME2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  w_frameCnt;
  logic        w_enterF0;
  logic        w_enterF1;

  logic        r_vsyncD;
  logic        r_vsyncRise;

  // row projection state
  logic        r_lineHit;
  logic        r_rowOpen;
  logic        r_rowPend;
  logic [3:0]  r_numRow;
  logic [31:0] r_rowValid;
  logic [10:0] r_rowMem [0:31];
  logic [10:0] r_rowData;

  // column scan state
  logic [H_DISP-1:0] r_colMap;
  logic        r_scanValid;
  logic [10:0] r_scanX;
  logic        r_scanBit;
  logic        r_doneArm;
  logic        r_colOpen;
  logic        r_colPend;
  logic [3:0]  r_numCol;
  logic [31:0] r_colValid;
  logic [10:0] r_colMem [0:31];
  logic [10:0] r_colData;
  logic        r_done;

  logic        w_pix;
  logic        w_hitNow;
  logic        w_lineEnd;
  logic        w_lastLine;
  logic        w_rowSat;
  logic        w_xInRange;
  logic [XW-1:0] w_xIdx;
  logic        w_scanPix;
  logic        w_colSat;
  logic        w_scanLast;

  logic        w_rowWe;
  logic [4:0]  w_rowWAddr;
  logic [10:0] w_rowWData;
  logic        w_rowInc;
  logic        w_rowOpenNext;
  logic        w_rowPendNext;

  logic        w_colWe;
  logic [4:0]  w_colWAddr;
  logic [10:0] w_colWData;
  logic        w_colInc;
  logic        w_colOpenNext;
  logic        w_colPendNext;
  logic        w_doneArmNext;

  logic        w_unusedAddr;

  assign w_unusedAddr = ^{row_border_addr[10:5], col_border_addr[10:5]};

  // Register vsync and produce a one-cycle pulse on its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsyncD    <= 1'b0;
      r_vsyncRise <= 1'b0;
    end else begin
      r_vsyncD    <= frame_vsync;
      r_vsyncRise <= frame_vsync & ~r_vsyncD;
    end
  end

  // Frame phase register; after reset we idle until the first vsync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Phase sequencing and frame-entry strobes.
  always_comb begin
    w_nextState = r_state;
    w_frameCnt  = 2'd0;
    case (r_state)
      S_WAIT: begin
        if (r_vsyncRise) w_nextState = S_FRAME0;
      end
      S_FRAME0: begin
        w_frameCnt = 2'd0;
        if (r_vsyncRise) w_nextState = S_FRAME1;
      end
      S_FRAME1: begin
        w_frameCnt = 2'd1;
        if (r_vsyncRise) w_nextState = S_FRAME2;
      end
      S_FRAME2: begin
        w_frameCnt = 2'd2;
        if (r_vsyncRise) w_nextState = S_FRAME0;
      end
      default: w_nextState = S_WAIT;
    endcase
    w_enterF0 = r_vsyncRise && (w_nextState == S_FRAME0);
    w_enterF1 = r_vsyncRise && (w_nextState == S_FRAME1);
  end

  assign w_pix      = data_en && (r_state == S_FRAME0);
  assign w_hitNow   = (xpos == 11'd0) ? ~monoc : (r_lineHit | ~monoc);
  assign w_lineEnd  = w_pix && (xpos == LP_XLAST);
  assign w_lastLine = (ypos == LP_YLAST);
  assign w_rowSat   = (r_numRow >= LP_NROW);
  assign w_xInRange = (xpos < LP_XCNT);
  assign w_xIdx     = xpos[XW-1:0];

  // Track whether the current line has any foreground pixel so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lineHit <= 1'b0;
    end else if (w_enterF0) begin
      r_lineHit <= 1'b0;
    end else if (w_pix) begin
      r_lineHit <= w_hitNow;
    end
  end

  // Column occupancy bitmap: line 0 overwrites, later lines accumulate.
  always_ff @(posedge clk) begin
    if (w_pix && w_xInRange) begin
      r_colMap[w_xIdx] <= ~monoc | ((ypos != 11'd0) & r_colMap[w_xIdx]);
    end
  end

  // Row segment decisions at each line end; a segment opened on the last
  // line is closed by a pending write on the following cycle.
  always_comb begin
    w_rowWe       = 1'b0;
    w_rowWAddr    = 5'd0;
    w_rowWData    = 11'd0;
    w_rowInc      = 1'b0;
    w_rowOpenNext = r_rowOpen;
    w_rowPendNext = 1'b0;
    if (!r_vsyncRise) begin
      if (r_rowPend) begin
        w_rowWe    = 1'b1;
        w_rowWAddr = {r_numRow, 1'b1};
        w_rowWData = LP_YLAST;
        w_rowInc   = 1'b1;
      end else if (w_lineEnd) begin
        if (w_hitNow && !r_rowOpen) begin
          if (!w_rowSat) begin
            w_rowWe    = 1'b1;
            w_rowWAddr = {r_numRow, 1'b0};
            w_rowWData = ypos;
            if (w_lastLine) w_rowPendNext = 1'b1;
            else            w_rowOpenNext = 1'b1;
          end
        end else if (w_hitNow && r_rowOpen && w_lastLine) begin
          w_rowWe       = 1'b1;
          w_rowWAddr    = {r_numRow, 1'b1};
          w_rowWData    = ypos;
          w_rowInc      = 1'b1;
          w_rowOpenNext = 1'b0;
        end else if (!w_hitNow && r_rowOpen) begin
          w_rowWe       = 1'b1;
          w_rowWAddr    = {r_numRow, 1'b1};
          w_rowWData    = ypos - 11'd1;
          w_rowInc      = 1'b1;
          w_rowOpenNext = 1'b0;
        end
      end
    end
  end

  // Row count, open flag and written-address tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_numRow   <= 4'd0;
      r_rowOpen  <= 1'b0;
      r_rowPend  <= 1'b0;
      r_rowValid <= 32'd0;
    end else if (w_enterF0) begin
      r_numRow   <= 4'd0;
      r_rowOpen  <= 1'b0;
      r_rowPend  <= 1'b0;
      r_rowValid <= 32'd0;
    end else if (r_vsyncRise) begin
      r_rowOpen <= 1'b0;
      r_rowPend <= 1'b0;
    end else begin
      if (w_rowWe) r_rowValid[w_rowWAddr] <= 1'b1;
      r_numRow  <= r_numRow + 4'(w_rowInc);
      r_rowOpen <= w_rowOpenNext;
      r_rowPend <= w_rowPendNext;
    end
  end

  // Row border storage.
  always_ff @(posedge clk) begin
    if (w_rowWe) r_rowMem[w_rowWAddr] <= w_rowWData;
  end

  // Registered row readout; never-written entries read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowData <= 11'd0;
    end else begin
      r_rowData <= r_rowValid[row_border_addr[4:0]] ? r_rowMem[row_border_addr[4:0]] : 11'd0;
    end
  end

  assign w_scanPix = data_en && (r_state == S_FRAME1) && (ypos == 11'd0) && !r_done;

  // Bitmap read stage for the frame 1 scan (one cycle of latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scanValid <= 1'b0;
      r_scanX     <= 11'd0;
      r_scanBit   <= 1'b0;
    end else begin
      r_scanValid <= w_scanPix;
      r_scanX     <= xpos;
      r_scanBit   <= w_scanPix && w_xInRange && r_colMap[w_xIdx];
    end
  end

  assign w_colSat   = (r_numCol >= LP_NCOL);
  assign w_scanLast = (r_scanX == LP_XLAST);

  // Column segment decisions on bitmap transitions along the scan.
  always_comb begin
    w_colWe       = 1'b0;
    w_colWAddr    = 5'd0;
    w_colWData    = 11'd0;
    w_colInc      = 1'b0;
    w_colOpenNext = r_colOpen;
    w_colPendNext = 1'b0;
    w_doneArmNext = 1'b0;
    if (!r_vsyncRise && (r_state == S_FRAME1)) begin
      if (r_colPend) begin
        w_colWe    = 1'b1;
        w_colWAddr = {r_numCol, 1'b1};
        w_colWData = LP_XLAST;
        w_colInc   = 1'b1;
      end else if (r_scanValid) begin
        w_doneArmNext = w_scanLast;
        if (r_scanBit && !r_colOpen) begin
          if (!w_colSat) begin
            w_colWe    = 1'b1;
            w_colWAddr = {r_numCol, 1'b0};
            w_colWData = r_scanX;
            if (w_scanLast) w_colPendNext = 1'b1;
            else            w_colOpenNext = 1'b1;
          end
        end else if (r_scanBit && r_colOpen && w_scanLast) begin
          w_colWe       = 1'b1;
          w_colWAddr    = {r_numCol, 1'b1};
          w_colWData    = r_scanX;
          w_colInc      = 1'b1;
          w_colOpenNext = 1'b0;
        end else if (!r_scanBit && r_colOpen) begin
          w_colWe       = 1'b1;
          w_colWAddr    = {r_numCol, 1'b1};
          w_colWData    = r_scanX - 11'd1;
          w_colInc      = 1'b1;
          w_colOpenNext = 1'b0;
        end
      end
    end
  end

  // Column count, open flag and written-address tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_numCol   <= 4'd0;
      r_colOpen  <= 1'b0;
      r_colPend  <= 1'b0;
      r_colValid <= 32'd0;
      r_doneArm  <= 1'b0;
    end else if (w_enterF1) begin
      r_numCol   <= 4'd0;
      r_colOpen  <= 1'b0;
      r_colPend  <= 1'b0;
      r_colValid <= 32'd0;
      r_doneArm  <= 1'b0;
    end else if (r_vsyncRise) begin
      r_colOpen <= 1'b0;
      r_colPend <= 1'b0;
      r_doneArm <= 1'b0;
    end else begin
      if (w_colWe) r_colValid[w_colWAddr] <= 1'b1;
      r_numCol  <= r_numCol + 4'(w_colInc);
      r_colOpen <= w_colOpenNext;
      r_colPend <= w_colPendNext;
      r_doneArm <= w_doneArmNext;
    end
  end

  // Column border storage.
  always_ff @(posedge clk) begin
    if (w_colWe) r_colMem[w_colWAddr] <= w_colWData;
  end

  // Registered column readout; never-written entries read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colData <= 11'd0;
    end else begin
      r_colData <= r_colValid[col_border_addr[4:0]] ? r_colMem[col_border_addr[4:0]] : 11'd0;
    end
  end

  // Results-valid flag: set after the scan, dropped when a new capture starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (w_enterF0) begin
      r_done <= 1'b0;
    end else if (r_doneArm && !r_vsyncRise && (r_state == S_FRAME1)) begin
      r_done <= 1'b1;
    end
  end

  assign frame_cnt         = w_frameCnt;
  assign project_done_flag = r_done;
  assign num_row           = r_numRow;
  assign num_col           = r_numCol;
  assign row_border_data   = r_rowData;
  assign col_border_data   = r_colData;

endmodule

// File: tb/tb_projection_border.sv
// Directed bench for projection_border on a reduced 96x48 raster.
module tb_projection_border;

  localparam int H = 96;
  localparam int V = 48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_vsync;
  logic        data_en;
  logic        monoc;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic [10:0] row_border_addr;
  logic [10:0] row_border_data;
  logic [10:0] col_border_addr;
  logic [10:0] col_border_data;
  logic [1:0]  frame_cnt;
  logic        project_done_flag;
  logic [3:0]  num_row;
  logic [3:0]  num_col;

  int testCount = 0;
  int failCount = 0;

  int boxXlo [8];
  int boxXhi [8];
  int boxYlo [8];
  int boxYhi [8];
  int numBoxes = 0;

  projection_border #(
    .H_DISP (H),
    .V_DISP (V),
    .NUM_ROW(1),
    .NUM_COL(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_vsync      (frame_vsync),
    .data_en          (data_en),
    .monoc            (monoc),
    .xpos             (xpos),
    .ypos             (ypos),
    .row_border_addr  (row_border_addr),
    .row_border_data  (row_border_data),
    .col_border_addr  (col_border_addr),
    .col_border_data  (col_border_data),
    .frame_cnt        (frame_cnt),
    .project_done_flag(project_done_flag),
    .num_row          (num_row),
    .num_col          (num_col)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  // Guard against a stalled run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic addBox(input int xlo, input int xhi, input int ylo, input int yhi);
    boxXlo[numBoxes] = xlo;
    boxXhi[numBoxes] = xhi;
    boxYlo[numBoxes] = ylo;
    boxYhi[numBoxes] = yhi;
    numBoxes++;
  endtask

  function automatic logic isInk(input int x, input int y);
    for (int i = 0; i < numBoxes; i++) begin
      if (x >= boxXlo[i] && x <= boxXhi[i] && y >= boxYlo[i] && y <= boxYhi[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic sendPixel(input int x, input int y);
    @(negedge clk);
    data_en = 1'b1;
    xpos    = 11'(x);
    ypos    = 11'(y);
    monoc   = ~isInk(x, y);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_en = 1'b0;
    monoc   = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseVsync();
    @(negedge clk);
    frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    frame_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One full capture: frame 0 raster, frame 1 scan line, then into frame 2.
  task automatic applyStimulus(input string name);
    pulseVsync();
    checkOutput({name, " cnt f0"}, 32'(frame_cnt), 32'd0);
    checkOutput({name, " done f0"}, 32'(project_done_flag), 32'd0);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) sendPixel(x, y);
    end
    idle(4);
    pulseVsync();
    checkOutput({name, " cnt f1"}, 32'(frame_cnt), 32'd1);
    for (int x = 0; x < H; x++) sendPixel(x, 0);
    idle(4);
    checkOutput({name, " done after scan"}, 32'(project_done_flag), 32'd1);
    pulseVsync();
    checkOutput({name, " cnt f2"}, 32'(frame_cnt), 32'd2);
    checkOutput({name, " done f2"}, 32'(project_done_flag), 32'd1);
  endtask

  task automatic checkCounts(input string name, input int nr, input int nc);
    checkOutput({name, " num_row"}, 32'(num_row), 32'(nr));
    checkOutput({name, " num_col"}, 32'(num_col), 32'(nc));
  endtask

  task automatic checkRow(input string name, input int addr, input int exp);
    @(negedge clk);
    row_border_addr = 11'(addr);
    @(negedge clk);
    checkOutput($sformatf("%s row[%0d]", name, addr), 32'(row_border_data), 32'(exp));
  endtask

  task automatic checkCol(input string name, input int addr, input int exp);
    @(negedge clk);
    col_border_addr = 11'(addr);
    @(negedge clk);
    checkOutput($sformatf("%s col[%0d]", name, addr), 32'(col_border_data), 32'(exp));
  endtask

  int fourCols [8];

  initial begin
    rst_n           = 1'b0;
    frame_vsync     = 1'b0;
    data_en         = 1'b0;
    monoc           = 1'b1;
    xpos            = 11'd0;
    ypos            = 11'd0;
    row_border_addr = 11'd0;
    col_border_addr = 11'd0;
    fourCols        = '{10, 17, 30, 37, 50, 57, 70, 77};

    repeat (3) @(negedge clk);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset done", 32'(project_done_flag), 32'd0);
    checkCounts("reset", 0, 0);
    checkOutput("reset row data", 32'(row_border_data), 32'd0);
    checkOutput("reset col data", 32'(col_border_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single box
    numBoxes = 0;
    addBox(10, 17, 20, 39);
    applyStimulus("one");
    checkCounts("one", 1, 1);
    checkRow("one", 0, 20);
    checkRow("one", 1, 39);
    checkRow("one", 2, 0);
    checkCol("one", 0, 10);
    checkCol("one", 1, 17);
    checkCol("one", 2, 0);

    // Four boxes side by side
    numBoxes = 0;
    addBox(10, 17, 20, 39);
    addBox(30, 37, 20, 39);
    addBox(50, 57, 20, 39);
    addBox(70, 77, 20, 39);
    applyStimulus("four");
    checkCounts("four", 1, 4);
    checkRow("four", 0, 20);
    checkRow("four", 1, 39);
    for (int i = 0; i < 8; i++) checkCol("four", i, fourCols[i]);

    // Five column boxes and a second row band: both saturate
    numBoxes = 0;
    addBox(10, 17, 20, 39);
    addBox(30, 37, 20, 39);
    addBox(50, 57, 20, 39);
    addBox(70, 77, 20, 39);
    addBox(85, 90, 20, 39);
    addBox(10, 17, 45, 46);
    applyStimulus("five");
    checkCounts("five", 1, 4);
    for (int i = 0; i < 8; i++) checkCol("five", i, fourCols[i]);
    checkCol("five", 8, 0);
    checkCol("five", 9, 0);
    checkRow("five", 1, 39);
    checkRow("five", 2, 0);

    // Box touching the right and bottom edges
    numBoxes = 0;
    addBox(80, 95, 30, 47);
    applyStimulus("edge");
    checkCounts("edge", 1, 1);
    checkRow("edge", 0, 30);
    checkRow("edge", 1, 47);
    checkCol("edge", 0, 80);
    checkCol("edge", 1, 95);

    // Single pixel in the last column of the last line
    numBoxes = 0;
    addBox(95, 95, 47, 47);
    applyStimulus("corner");
    checkCounts("corner", 1, 1);
    checkRow("corner", 0, 47);
    checkRow("corner", 1, 47);
    checkCol("corner", 0, 95);
    checkCol("corner", 1, 95);

    // Blank frame
    numBoxes = 0;
    applyStimulus("white");
    checkCounts("white", 0, 0);
    checkRow("white", 0, 0);
    checkCol("white", 0, 0);

    // Reset in the middle of the frame 1 scan, then a clean capture
    numBoxes = 0;
    addBox(10, 17, 20, 39);
    pulseVsync();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) sendPixel(x, y);
    end
    idle(4);
    pulseVsync();
    checkOutput("midrst cnt f1", 32'(frame_cnt), 32'd1);
    for (int x = 0; x < 40; x++) sendPixel(x, 0);
    idle(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("midrst done", 32'(project_done_flag), 32'd0);
    checkCounts("midrst", 0, 0);
    checkOutput("midrst row data", 32'(row_border_data), 32'd0);
    checkOutput("midrst col data", 32'(col_border_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus("after rst");
    checkCounts("after rst", 1, 1);
    checkRow("after rst", 0, 20);
    checkRow("after rst", 1, 39);
    checkCol("after rst", 0, 10);
    checkCol("after rst", 1, 17);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/projection_border.md
PROJECTION_BORDER -- requirements
Module: projection_border

Interface
REQ-001 Parameter H_DISP, default 640, meaning active pixels per line.
REQ-002 Parameter V_DISP, default 480, meaning active lines per frame.
REQ-003 Parameter NUM_ROW, default 1, meaning maximum row segments stored.
REQ-004 Parameter NUM_COL, default 4, meaning maximum column segments stored.
REQ-005 clk  in  1  pixel clock; the block has one clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_vsync  in  1  frame sync; a rising edge marks a frame start.
REQ-008 data_en  in  1  pixel valid.
REQ-009 monoc  in  1  binary pixel; 0 = foreground (digit), 1 = background.
REQ-010 xpos, ypos  in  11 each  coordinates of the current valid pixel.
REQ-011 row_border_addr  in  11  read address for row borders.
REQ-012 row_border_data  out  11  registered row border read data.
REQ-013 col_border_addr  in  11  read address for column borders.
REQ-014 col_border_data  out  11  registered column border read data.
REQ-015 frame_cnt  out  2  frame phase: 0, 1, 2.
REQ-016 project_done_flag  out  1  high while the border RAMs and counts are valid.
REQ-017 num_row, num_col  out  4 each  number of closed segments stored.

Function
REQ-018 frame_cnt SHALL advance on each frame_vsync rising edge in the sequence 0->1->2->0, one clk after the edge is detected.
REQ-019 Frame 0, row projection: a line_hit flag SHALL be set by any data_en pixel with monoc=0, and cleared at line start (xpos=0).
REQ-020 Frame 0, line end (data_en, xpos=H_DISP-1): hit on a line following a non-hit line SHALL open a segment by writing ypos to row RAM address 2*num_row.
REQ-021 Frame 0, line end: no hit on a line following a hit line SHALL write ypos-1 to address 2*num_row+1 and increment num_row.
REQ-022 Frame 0: a segment still open at line V_DISP-1 SHALL be closed with V_DISP-1 as its high border.
REQ-023 Frame 0 SHALL clear the H_DISP x 1 column bitmap as it goes and set bit[xpos] for every data_en pixel with monoc=0.
REQ-024 Frame 1, line ypos=0: the bitmap SHALL be read with 1-cycle latency and scanned in xpos order.
REQ-025 Frame 1 scan: a 0->1 bitmap transition SHALL write x to column RAM address 2*num_col (left border).
REQ-026 Frame 1 scan: a 1->0 bitmap transition SHALL write x-1 to address 2*num_col+1 (right border) and increment num_col.
REQ-027 Frame 1 scan: a column segment still open at H_DISP-1 SHALL be closed with right border H_DISP-1.
REQ-028 Saturation: once num_row=NUM_ROW, further row segments SHALL be ignored and cause no write; likewise once num_col=NUM_COL.
REQ-029 num_row and num_col SHALL be cleared at the start of frames 0 and 1 respectively.
REQ-030 project_done_flag SHALL set when the frame 1 scan completes and stay high through frame 2.
REQ-031 project_done_flag SHALL clear on the vsync edge that returns frame_cnt to 0; RAMs, num_row and num_col SHALL be held stable while it is high.
REQ-032 RAM reads SHALL return data one clk after the address, using address bits [4:0]; addresses not yet written SHALL read 0.
REQ-033 Simultaneous write and read to the same address SHALL return the old data.
REQ-034 If frame_vsync rises mid-frame, the phase SHALL still advance; open segments SHALL be discarded without a write, and num_* SHALL keep only closed segments.
REQ-035 The pipeline SHALL be fully synchronous; the only asynchronous input is rst_n.

Reset
REQ-036 rst_n low: frame_cnt=0, project_done_flag=0, num_row=0, num_col=0, read data=0, line_hit=0, edge registers=0; RAM contents are don't-care.
REQ-037 Reset released mid-frame: the block SHALL wait for the next frame_vsync rising edge before capturing, then start in phase 0.

Verification
REQ-038 Black box rows 100-199, x 50-89 -> row RAM {100,199}, num_row=1; col RAM {50,89}, num_col=1; flag high in frame 2.
REQ-039 Four boxes x 50-89/150-189/250-289/350-389, rows 100-199 -> col RAM 50,89,150,189,250,289,350,389; num_col=4.
REQ-040 Five boxes with NUM_COL=4 -> num_col=4, fifth segment absent, RAM address 8 unwritten and reads 0.
REQ-041 Box touching x=639 and y=479 -> right border 639, high border 479, both closed.
REQ-042 All-white frame -> num_row=0, num_col=0, flag high in frame 2, col RAM address 0 reads 0.
REQ-043 rst_n pulsed low during frame 1 -> all outputs 0; the next vsync gives frame_cnt=0; borders are correct after a further full cycle.
